// File: rtl/ddr3_cmd_scheduler.sv
// DDR3 command front-end: init wait + ZQ calibration, postponable periodic refresh,
// and round-robin arbitration of two requesters onto a closed-page ACT / CAS-with-AP path.
module ddr3_cmd_scheduler #(
   parameter int unsigned T_INIT  = 16,
   parameter int unsigned T_ZQ    = 8,
   parameter int unsigned T_REFI  = 780,
   parameter int unsigned T_RFC   = 10,
   parameter int unsigned T_RCD   = 3,
   parameter int unsigned T_RP_AP = 6
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        RW0,
   input  logic        RW1,
   input  logic [14:0] ROW0,
   input  logic [14:0] ROW1,
   input  logic [9:0]  COL0,
   input  logic [9:0]  COL1,
   input  logic [2:0]  BA0,
   input  logic [2:0]  BA1,
   input  logic [15:0] WDATA0,
   input  logic [15:0] WDATA1,
   output logic        ACK0,
   output logic        ACK1,
   output logic        ZQCL,
   output logic        REF,
   output logic        ACT,
   output logic        WRITE_AP,
   output logic        READ_AP,
   output logic [14:0] Addr_Row,
   output logic [9:0]  Addr_Column,
   output logic [2:0]  BA_out,
   output logic        A_10,
   output logic        A_12,
   output logic [15:0] DQ_wr,
   output logic        INIT_DONE,
   output logic        BUSY,
   output logic [3:0]  REF_PENDING
);

   typedef enum logic [3:0] {
      INIT_WAIT, ZQ_ISSUE, ZQ_WAIT, IDLE, REF_ISSUE,
      REF_WAIT, ACT_ISSUE, RCD_WAIT, CAS_ISSUE, AP_WAIT
   } state_t;

   // Last-cycle values of the per-state dwell counter.
   localparam logic [15:0] INIT_LAST = 16'(T_INIT - 1);
   localparam logic [15:0] ZQ_LAST   = 16'(T_ZQ - 1);
   localparam logic [15:0] RFC_LAST  = 16'(T_RFC - 2);
   localparam logic [15:0] RCD_LAST  = 16'(T_RCD - 2);
   localparam logic [15:0] AP_LAST   = 16'(T_RP_AP - 1);
   localparam logic [15:0] REFI_LAST = 16'(T_REFI - 1);

   state_t      state, state_nxt;
   logic [15:0] state_cnt;
   logic [15:0] refi_cnt;
   logic        refi_tick;
   logic        ref_dec;
   logic        grant;
   logic        grant_port;
   logic        last_grant;
   logic        lat_port;
   logic        lat_rw;
   logic [14:0] lat_row;
   logic [9:0]  lat_col;
   logic [2:0]  lat_ba;
   logic [15:0] lat_wdata;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= INIT_WAIT;
         state_cnt <= '0;
      end else begin
         state     <= state_nxt;
         state_cnt <= (state_nxt != state || state == IDLE) ? '0 : state_cnt + 16'd1;
      end
   end

   // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         INIT_WAIT: if (state_cnt == INIT_LAST) state_nxt = ZQ_ISSUE;
         ZQ_ISSUE:  state_nxt = ZQ_WAIT;
         ZQ_WAIT:   if (state_cnt == ZQ_LAST) state_nxt = IDLE;
         IDLE: begin
            if (REF_PENDING != 4'd0)  state_nxt = REF_ISSUE;
            else if (REQ0 || REQ1)    state_nxt = ACT_ISSUE;
         end
         REF_ISSUE: state_nxt = REF_WAIT;
         REF_WAIT:  if (state_cnt == RFC_LAST) state_nxt = IDLE;
         ACT_ISSUE: state_nxt = RCD_WAIT;
         RCD_WAIT:  if (state_cnt == RCD_LAST) state_nxt = CAS_ISSUE;
         CAS_ISSUE: state_nxt = AP_WAIT;
         AP_WAIT:   if (state_cnt == AP_LAST) state_nxt = IDLE;
         default:   state_nxt = INIT_WAIT;
      endcase
   end

   // Tie goes to the port that did not win last time.
   assign grant      = (state == IDLE) && (REF_PENDING == 4'd0) && (REQ0 || REQ1);
   assign grant_port = (REQ0 && REQ1) ? ~last_grant : REQ1;

   // NOTE: the request latches are reset because they drive the address/data pins directly.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_grant <= 1'b1;
         lat_port   <= 1'b0;
         lat_rw     <= 1'b0;
         lat_row    <= '0;
         lat_col    <= '0;
         lat_ba     <= '0;
         lat_wdata  <= '0;
      end else if (grant) begin
         last_grant <= grant_port;
         lat_port   <= grant_port;
         lat_rw     <= grant_port ? RW1    : RW0;
         lat_row    <= grant_port ? ROW1   : ROW0;
         lat_col    <= grant_port ? COL1   : COL0;
         lat_ba     <= grant_port ? BA1    : BA0;
         lat_wdata  <= grant_port ? WDATA1 : WDATA0;
      end
   end

   assign refi_tick = INIT_DONE && (refi_cnt == REFI_LAST);
   assign ref_dec   = (state == REF_ISSUE);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         refi_cnt    <= '0;
         REF_PENDING <= '0;
      end else begin
         if (INIT_DONE) refi_cnt <= refi_tick ? '0 : refi_cnt + 16'd1;
         // Owed refreshes saturate at 8; a tick and an issue in one cycle cancel.
         case ({refi_tick, ref_dec})
            2'b10:   if (REF_PENDING != 4'd8) REF_PENDING <= REF_PENDING + 4'd1;
            2'b01:   REF_PENDING <= REF_PENDING - 4'd1;
            default: REF_PENDING <= REF_PENDING;
         endcase
      end
   end

   always_comb begin
      ZQCL      = 1'b0;
      REF       = 1'b0;
      ACT       = 1'b0;
      WRITE_AP  = 1'b0;
      READ_AP   = 1'b0;
      ACK0      = 1'b0;
      ACK1      = 1'b0;
      case (state)
         ZQ_ISSUE:  ZQCL = 1'b1;
         REF_ISSUE: REF  = 1'b1;
         ACT_ISSUE: ACT  = 1'b1;
         CAS_ISSUE: begin
            WRITE_AP = lat_rw;
            READ_AP  = !lat_rw;
            ACK0     = !lat_port;
            ACK1     = lat_port;
         end
         default: ;
      endcase
      INIT_DONE = !(state inside {INIT_WAIT, ZQ_ISSUE, ZQ_WAIT});
      BUSY      = (state != IDLE);
      DQ_wr     = (state == CAS_ISSUE && lat_rw) ? lat_wdata : '0;
   end

   assign Addr_Row    = lat_row;
   assign Addr_Column = lat_col;
   assign BA_out      = lat_ba;
   assign A_10        = 1'b1;
   assign A_12        = 1'b1;

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Self-checking bench: two scheduler instances (normal refresh rate, and a fast refresh
// rate that forces saturation) compared every cycle against a schedule-based model.
module tb_ddr3_cmd_scheduler;

   localparam int T_INIT   = 16;
   localparam int T_ZQ     = 8;
   localparam int T_REFI_A = 30;
   localparam int T_REFI_B = 4;
   localparam int T_RFC    = 10;
   localparam int T_RCD    = 3;
   localparam int T_RP_AP  = 6;
   localparam int INIT_END = T_INIT + 1 + T_ZQ;

   typedef struct packed {
      logic        req;
      logic        rw;
      logic [14:0] row;
      logic [9:0]  col;
      logic [2:0]  ba;
      logic [15:0] wd;
   } port_in_t;

   logic CLK = 1'b0;
   logic RESET_N;
   always #5 CLK = ~CLK;

   port_in_t pa  [2];
   port_in_t dir [2];
   int       mode;
   logic [1:0] ack_s;

   logic [1:0] zqcl, ref_s, act, wr_ap, rd_ap, ack0, ack1, a10, a12, init_done, busy;
   logic [1:0][14:0] row;
   logic [1:0][9:0]  col;
   logic [1:0][2:0]  ba;
   logic [1:0][15:0] dq;
   logic [1:0][3:0]  pend;

   int n_tests = 0;
   int n_fail  = 0;

   ddr3_cmd_scheduler #(.T_INIT(T_INIT), .T_ZQ(T_ZQ), .T_REFI(T_REFI_A), .T_RFC(T_RFC),
                        .T_RCD(T_RCD), .T_RP_AP(T_RP_AP)) dut_a (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(pa[0].req), .REQ1(pa[1].req), .RW0(pa[0].rw), .RW1(pa[1].rw),
      .ROW0(pa[0].row), .ROW1(pa[1].row), .COL0(pa[0].col), .COL1(pa[1].col),
      .BA0(pa[0].ba), .BA1(pa[1].ba), .WDATA0(pa[0].wd), .WDATA1(pa[1].wd),
      .ACK0(ack0[0]), .ACK1(ack1[0]), .ZQCL(zqcl[0]), .REF(ref_s[0]), .ACT(act[0]),
      .WRITE_AP(wr_ap[0]), .READ_AP(rd_ap[0]), .Addr_Row(row[0]), .Addr_Column(col[0]),
      .BA_out(ba[0]), .A_10(a10[0]), .A_12(a12[0]), .DQ_wr(dq[0]),
      .INIT_DONE(init_done[0]), .BUSY(busy[0]), .REF_PENDING(pend[0])
   );

   ddr3_cmd_scheduler #(.T_INIT(T_INIT), .T_ZQ(T_ZQ), .T_REFI(T_REFI_B), .T_RFC(T_RFC),
                        .T_RCD(T_RCD), .T_RP_AP(T_RP_AP)) dut_b (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(1'b0), .REQ1(1'b0), .RW0(1'b0), .RW1(1'b0),
      .ROW0(15'd0), .ROW1(15'd0), .COL0(10'd0), .COL1(10'd0),
      .BA0(3'd0), .BA1(3'd0), .WDATA0(16'd0), .WDATA1(16'd0),
      .ACK0(ack0[1]), .ACK1(ack1[1]), .ZQCL(zqcl[1]), .REF(ref_s[1]), .ACT(act[1]),
      .WRITE_AP(wr_ap[1]), .READ_AP(rd_ap[1]), .Addr_Row(row[1]), .Addr_Column(col[1]),
      .BA_out(ba[1]), .A_10(a10[1]), .A_12(a12[1]), .DQ_wr(dq[1]),
      .INIT_DONE(init_done[1]), .BUSY(busy[1]), .REF_PENDING(pend[1])
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: each instance is described by the cycle numbers at which its
   // scheduled events fall, plus the owed-refresh count.
   int m_c [2], m_pend [2], m_idle_at [2], m_ref_at [2], m_act_at [2], m_cas_at [2];
   int m_lg [2], m_port [2], m_rw [2], m_row [2], m_col [2], m_ba [2], m_wd [2];

   function automatic int refi_of(input int i);
      return (i == 0) ? T_REFI_A : T_REFI_B;
   endfunction

   task automatic model_reset(input int i);
      m_c[i] = 0;  m_pend[i] = 0;  m_idle_at[i] = INIT_END;
      m_ref_at[i] = -100;  m_act_at[i] = -100;  m_cas_at[i] = -100;
      m_lg[i] = 1;  m_port[i] = 0;  m_rw[i] = 0;
      m_row[i] = 0;  m_col[i] = 0;  m_ba[i] = 0;  m_wd[i] = 0;
   endtask

   // {ZQCL, REF, ACT, WRITE_AP, READ_AP, ACK0, ACK1, INIT_DONE, BUSY}
   function automatic logic [8:0] exp_strobes(input int i);
      int   c;
      logic cas;
      c   = m_c[i];
      cas = (c == m_cas_at[i]);
      return {c == T_INIT, c == m_ref_at[i], c == m_act_at[i],
              cas && m_rw[i] == 1, cas && m_rw[i] == 0,
              cas && m_port[i] == 0, cas && m_port[i] == 1,
              c >= INIT_END, c < m_idle_at[i]};
   endfunction

   task automatic model_step(input int i, input port_in_t p0, input port_in_t p1);
      int       c, port;
      bit       tick, dec;
      port_in_t pick;
      c    = m_c[i];
      tick = (c >= INIT_END) && ((c - INIT_END) % refi_of(i) == refi_of(i) - 1);
      dec  = (c == m_ref_at[i]);
      if (c >= m_idle_at[i]) begin
         if (m_pend[i] != 0) begin
            m_ref_at[i]  = c + 1;
            m_idle_at[i] = c + 1 + T_RFC;
         end else if (p0.req || p1.req) begin
            if (p0.req && p1.req) port = 1 - m_lg[i];
            else                  port = p1.req ? 1 : 0;
            pick = (port == 1) ? p1 : p0;
            m_lg[i] = port;  m_port[i] = port;  m_rw[i] = pick.rw;
            m_row[i] = pick.row;  m_col[i] = pick.col;  m_ba[i] = pick.ba;  m_wd[i] = pick.wd;
            m_act_at[i]  = c + 1;
            m_cas_at[i]  = c + 1 + T_RCD;
            m_idle_at[i] = c + 2 + T_RCD + T_RP_AP;
         end
      end
      if (tick && !dec)      m_pend[i] = (m_pend[i] < 8) ? m_pend[i] + 1 : 8;
      else if (dec && !tick) m_pend[i] = m_pend[i] - 1;
      m_c[i] = c + 1;
   endtask

   // Compare process: every cycle, both instances, all outputs.
   always @(negedge CLK) begin
      port_in_t zp;
      zp = '0;
      for (int i = 0; i < 2; i++) begin
         logic [8:0] got;
         got = {zqcl[i], ref_s[i], act[i], wr_ap[i], rd_ap[i], ack0[i], ack1[i], init_done[i], busy[i]};
         if (!RESET_N) begin
            model_reset(i);
            check($sformatf("rst_strobes[%0d]", i), 32'(got), 32'h001);
            check($sformatf("rst_pending[%0d]", i), 32'(pend[i]), 0);
            check($sformatf("rst_addr[%0d]", i), {row[i], col[i], ba[i]}, 0);
            check($sformatf("rst_dq[%0d]", i), 32'(dq[i]), 0);
         end else begin
            logic [8:0] e;
            e = exp_strobes(i);
            check($sformatf("strobes[%0d]@%0d", i, m_c[i]), 32'(got), 32'(e));
            check($sformatf("pending[%0d]@%0d", i, m_c[i]), 32'(pend[i]), m_pend[i]);
            check($sformatf("row[%0d]@%0d", i, m_c[i]), 32'(row[i]), m_row[i]);
            check($sformatf("col[%0d]@%0d", i, m_c[i]), 32'(col[i]), m_col[i]);
            check($sformatf("ba[%0d]@%0d", i, m_c[i]), 32'(ba[i]), m_ba[i]);
            check($sformatf("dq[%0d]@%0d", i, m_c[i]), 32'(dq[i]), e[5] ? m_wd[i] : 0);
            check($sformatf("a10_a12[%0d]", i), {a10[i], a12[i]}, 32'h3);
            if (i == 0) model_step(0, pa[0], pa[1]);
            else        model_step(1, zp, zp);
         end
      end
   end

   // Stimulus driver for instance A: random traffic (mode 0) or directed values (other modes).
   always begin
      @(negedge CLK);
      ack_s = {ack1[0], ack0[0]};
      @(posedge CLK);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (mode == 0) begin
            pa[p].rw  = 1'($urandom_range(0, 1));
            pa[p].row = 15'($urandom);
            pa[p].col = 10'($urandom);
            pa[p].ba  = 3'($urandom);
            pa[p].wd  = 16'($urandom);
            if (!pa[p].req)    pa[p].req = ($urandom_range(0, 3) == 0);
            else if (ack_s[p]) pa[p].req = 1'($urandom_range(0, 1));
         end else begin
            pa[p] = dir[p];
         end
      end
   end

   initial begin
      int n, zq_cyc, id_cyc, b_last, nsp, maxp, nack, ref_cyc, act_after_ref, first_ack;
      int order [4];
      RESET_N = 1'b0;
      mode    = 2;
      dir[0]  = '0;
      dir[1]  = '0;
      pa[0]   = '0;
      pa[1]   = '0;
      repeat (3) @(posedge CLK);
      #3 RESET_N = 1'b1;

      // Init sequence: ZQCL at cycle 16, INIT_DONE from cycle 25.
      zq_cyc = -1;
      id_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (zqcl[0] && zq_cyc < 0)      zq_cyc = k;
         if (init_done[0] && id_cyc < 0) id_cyc = k;
      end
      check("init_zqcl_cycle", zq_cyc, 16);
      check("init_done_cycle", id_cyc, 25);

      // Single write on port 0.
      dir[0].req = 1'b1;  dir[0].rw = 1'b1;  dir[0].row = 15'h1;
      dir[0].col = 10'h8; dir[0].ba = 3'h2;  dir[0].wd  = 16'hBEEF;
      n = 0;
      while (!act[0] && n < 30) begin @(negedge CLK); n++; end
      check("write_act_seen", act[0], 1);
      check("write_act_row", row[0], 15'h1);
      check("write_act_ba", ba[0], 3'h2);
      dir[0].row = 15'h7FFF;
      dir[0].wd  = 16'h1234;
      n = 0;
      while (!wr_ap[0] && n < 30) begin @(negedge CLK); n++; end
      check("write_cas_offset", n, 3);
      check("write_ack0", {ack0[0], ack1[0]}, 2'b10);
      check("write_col", col[0], 10'h8);
      check("write_dq", dq[0], 16'hBEEF);
      dir[0].req = 1'b0;
      n = 0;
      while (busy[0] && n < 30) begin @(negedge CLK); n++; end
      check("write_idle_offset", n, 7);

      // Random traffic on A; B saturates its refresh backlog meanwhile.
      mode   = 0;
      b_last = -1;
      nsp    = 0;
      maxp   = 0;
      for (int k = 0; k < 1500; k++) begin
         @(negedge CLK);
         if (int'(pend[1]) > maxp) maxp = int'(pend[1]);
         if (ref_s[1]) begin
            if (b_last >= 0 && nsp < 5) begin
               check("sat_ref_spacing", k - b_last, 11);
               nsp++;
            end
            b_last = k;
         end
      end
      check("sat_spacing_count", nsp, 5);
      check("sat_pending_max", maxp, 8);

      // Reset during RCD_WAIT of an access in flight.
      n = 0;
      while (!act[0] && n < 300) begin @(negedge CLK); n++; end
      check("rst_found_act", act[0], 1);
      @(posedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      check("rst_async_strobes",
            {zqcl[0], ref_s[0], act[0], wr_ap[0], rd_ap[0], ack0[0], ack1[0], init_done[0], busy[0]},
            32'h001);
      check("rst_async_row", row[0], 0);
      check("rst_async_pending_b", pend[1], 0);

      // Contention after fresh init: both ports held high, port 0 reads, port 1 writes.
      mode = 1;
      dir[0].req = 1'b1;  dir[0].rw = 1'b0;  dir[0].row = 15'h0123;
      dir[0].col = 10'h045; dir[0].ba = 3'h5; dir[0].wd = 16'hAAAA;
      dir[1].req = 1'b1;  dir[1].rw = 1'b1;  dir[1].row = 15'h4567;
      dir[1].col = 10'h2AB; dir[1].ba = 3'h6; dir[1].wd = 16'hC0DE;
      repeat (3) @(posedge CLK);
      #3 RESET_N = 1'b1;
      nack          = 0;
      ref_cyc       = -1;
      act_after_ref = -1000;
      first_ack     = -1;
      for (int k = 0; k < 200 && nack < 4; k++) begin
         @(negedge CLK);
         if (ref_s[0] && ref_cyc < 0) ref_cyc = k;
         if (act[0] && ref_cyc >= 0 && act_after_ref < 0) act_after_ref = k;
         if (ack0[0] || ack1[0]) begin
            if (first_ack < 0) first_ack = k;
            order[nack] = ack1[0] ? 1 : 0;
            nack++;
         end
      end
      check("contend_ack_count", nack, 4);
      check("contend_first_ack_cycle", first_ack, 29);
      for (int i = 0; i < 4; i++)
         check($sformatf("contend_grant%0d", i), (i < nack) ? order[i] : -1, i % 2);
      check("preempt_ref_to_act", act_after_ref - ref_cyc, T_RFC + 1);

      // More random traffic after the contention phase.
      mode = 0;
      repeat (300) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
